// File: rtl/product_writer.sv
// product_writer: packs 64/96/128-bit multiplier products into 64-bit words.
// Words go to consecutive addresses of an internal result bank, low word
// first, and a registered read port exposes the bank contents.
module product_writer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     mode,
    input  logic           prod_valid,
    output logic           prod_ready,
    input  logic [127:0]   product,
    input  logic           flush,
    input  logic [AW-1:0]  rd_addr,
    output logic [63:0]    rd_data,
    output logic [AW-1:0]  wr_ptr,
    output logic [AW:0]    fill,
    output logic           full
);

    typedef enum logic {
        IDLE = 1'b0,
        HI   = 1'b1
    } state_e;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    fill_q;
    logic [63:0]    hi_q;
    logic [1:0]     mode_q;
    logic [63:0]    rd_data_q;
    logic [63:0]    bank_q [DEPTH];

    logic [AW:0]    space;
    logic [AW:0]    wpp;
    logic           accept;
    logic           bank_we;
    logic [63:0]    bank_wdata;

    // Free space and words needed by the product format currently presented.
    assign space = DEPTH_W - fill_q;
    assign wpp   = mode[1] ? (AW+1)'(2) : (AW+1)'(1);

    // State register; reset aborts any pending upper-word write.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush always returns to IDLE and drops a pending HI.
    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept && mode[1]) state_d = HI;
                HI:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: handshake, bank write enable and write word selection.
    always_comb begin
        prod_ready = (state_q == IDLE) && (space >= wpp) && !flush;
        accept     = prod_valid && prod_ready;
        bank_we    = accept || ((state_q == HI) && !flush);
        bank_wdata = product[63:0];
        if (state_q == HI) begin
            // Latched mode decides the upper word width, not the live input.
            bank_wdata = mode_q[0] ? hi_q : {32'h0, hi_q[31:0]};
        end
    end

    // Write pointer, fill count and upper-half latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            hi_q     <= '0;
            mode_q   <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                fill_q   <= '0;
            end else if (bank_we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                fill_q   <= fill_q + 1'b1;
            end
            if (accept && mode[1]) begin
                hi_q   <= product[127:64];
                mode_q <= mode;
            end
        end
    end

    // Result bank write port.
    // NOTE: the bank storage has no reset; it maps onto plain RAM and its
    // contents are only meaningful once written.
    always_ff @(posedge clock) begin
        if (bank_we) begin
            bank_q[wr_ptr_q] <= bank_wdata;
        end
    end

    // Registered read port; a same-edge write to rd_addr returns old data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bank_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign wr_ptr  = wr_ptr_q;
    assign fill    = fill_q;
    assign full    = (fill_q == DEPTH_W);

endmodule

// File: tb/tb_product_writer.sv
// Directed testbench for product_writer with hand-computed expectations.
module tb_product_writer;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic           clock;
    logic           reset;
    logic [1:0]     mode;
    logic           prod_valid;
    logic           prod_ready;
    logic [127:0]   product;
    logic           flush;
    logic [AW-1:0]  rd_addr;
    logic [63:0]    rd_data;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    fill;
    logic           full;

    int n_checks = 0;
    int n_pass   = 0;

    product_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .product    (product),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_ptr     (wr_ptr),
        .fill       (fill),
        .full       (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read one bank word through the registered port.
    task automatic read_word(input logic [AW-1:0] addr, output logic [63:0] data);
        rd_addr = addr;
        tick();
        data = rd_data;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    logic [63:0] d;

    initial begin
        reset      = 1'b0;
        mode       = 2'd0;
        prod_valid = 1'b0;
        product    = '0;
        flush      = 1'b0;
        rd_addr    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_fill", fill, 0);
        check("rst_full", full, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ready", prod_ready, 1);
        reset = 1'b1;
        tick();

        // Three back-to-back 64-bit products.
        mode = 2'd0; prod_valid = 1'b1; product = 128'h1;
        #1 check("m0_ready", prod_ready, 1);
        tick(); product = 128'h2;
        #1 check("m0_ready_b2b", prod_ready, 1);
        tick(); product = 128'h3;
        tick(); prod_valid = 1'b0;
        check("m0_wr_ptr", wr_ptr, 3);
        check("m0_fill", fill, 3);
        read_word(5'd1, d); check("m0_bank1", d, 64'h2);
        read_word(5'd0, d); check("m0_bank0", d, 64'h1);
        read_word(5'd2, d); check("m0_bank2", d, 64'h3);

        // Flush blocks ready in its own cycle and clears pointer/fill.
        flush = 1'b1;
        #1 check("flush_ready", prod_ready, 0);
        tick(); flush = 1'b0;
        check("flush_wr_ptr", wr_ptr, 0);
        check("flush_fill", fill, 0);

        // 128-bit product: two words, ready low for exactly the HI cycle.
        mode = 2'd3; product = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444; prod_valid = 1'b1;
        tick(); prod_valid = 1'b0;
        #1 check("m3_hi_ready", prod_ready, 0);
        check("m3_hi_fill", fill, 1);
        tick();
        check("m3_ready_back", prod_ready, 1);
        check("m3_fill", fill, 2);
        check("m3_wr_ptr", wr_ptr, 2);
        read_word(5'd0, d); check("m3_bank0", d, 64'h1111_2222_3333_4444);
        read_word(5'd1, d); check("m3_bank1", d, 64'hAAAA_BBBB_CCCC_DDDD);

        // 96-bit product with junk above bit 95; mode toggled during HI.
        do_flush();
        mode = 2'd2; product = 128'hFFFF_FFFF_FFFF_FFFF_0123_4567_89AB_CDEF; prod_valid = 1'b1;
        tick(); prod_valid = 1'b0; mode = 2'd0;
        tick();
        check("m2_fill", fill, 2);
        read_word(5'd0, d); check("m2_bank0", d, 64'h0123_4567_89AB_CDEF);
        read_word(5'd1, d); check("m2_bank1", d, 64'h0000_0000_FFFF_FFFF);

        // Read-before-write: address 2 still holds 3 from the first run.
        rd_addr = 5'd2; mode = 2'd0; product = 128'h55; prod_valid = 1'b1;
        tick(); prod_valid = 1'b0;
        check("rbw_old", rd_data, 64'h3);
        tick();
        check("rbw_new", rd_data, 64'h55);
        check("rbw_fill", fill, 3);

        // Space check: 31 words, then a 2-word product must be refused.
        do_flush();
        mode = 2'd0; prod_valid = 1'b1;
        for (int i = 0; i < 31; i++) begin
            product = 128'(100 + i);
            tick();
        end
        check("sp_fill31", fill, 31);
        check("sp_wr_ptr31", wr_ptr, 31);
        mode = 2'd3; product = 128'hDEAD_BEEF;
        #1 check("sp_m3_ready", prod_ready, 0);
        tick();
        check("sp_no_write", fill, 31);
        mode = 2'd0;
        #1 check("sp_m0_ready", prod_ready, 1);
        tick(); prod_valid = 1'b0;
        check("sp_fill32", fill, 32);
        check("sp_full", full, 1);
        check("sp_ready_full", prod_ready, 0);
        check("sp_wrap", wr_ptr, 0);
        read_word(5'd31, d); check("sp_bank31", d, 64'hDEAD_BEEF);
        read_word(5'd30, d); check("sp_bank30", d, 64'd130);

        // Flush during HI discards the upper word.
        do_flush();
        check("fh_not_full", full, 0);
        mode = 2'd3; product = 128'h9999_9999_9999_9999_7777_7777_7777_7777; prod_valid = 1'b1;
        tick(); prod_valid = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        #1 check("fh_ready", prod_ready, 1);
        check("fh_wr_ptr", wr_ptr, 0);
        check("fh_fill", fill, 0);
        read_word(5'd0, d); check("fh_bank0", d, 64'h7777_7777_7777_7777);
        read_word(5'd1, d); check("fh_bank1", d, 64'd101);

        // Reset during HI aborts the upper write.
        mode = 2'd3; product = 128'h5555_5555_5555_5555_3333_3333_3333_3333; prod_valid = 1'b1;
        tick(); prod_valid = 1'b0;
        check("rh_in_hi", prod_ready, 0);
        reset = 1'b0;
        #1;
        check("rh_wr_ptr", wr_ptr, 0);
        check("rh_fill", fill, 0);
        check("rh_rd_data", rd_data, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rh_ready", prod_ready, 1);
        check("rh_fill_after", fill, 0);
        read_word(5'd0, d); check("rh_bank0", d, 64'h3333_3333_3333_3333);
        read_word(5'd1, d); check("rh_bank1", d, 64'd101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
